// File: rtl/decode_stage_pkg.sv
// Shared pipeline definitions: widths, MIPS opcode constants and the bypass bundle
// that every producer stage (EX/MEM/WB) presents to ID.
package decode_stage_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  // Stores occupy opcodes 6'b101xxx.
  localparam logic [5:0] OP_STORE_MASK  = 6'b111000;
  localparam logic [5:0] OP_STORE_MATCH = 6'b101000;

  localparam logic [ADDR_WIDTH-1:0] REG_RA = 5'd31;

  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } bypass_t;

  function automatic logic is_store(input logic [5:0] op);
    return (op & OP_STORE_MASK) == OP_STORE_MATCH;
  endfunction

endpackage

// File: rtl/decode_stage_fwd.sv
// Operand resolver for one source register: picks the youngest in-flight producer
// (EX > MEM > WB > register file) and flags results that are not ready yet.
module fwd_mux
  import decode_stage_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  uses,
  input  bypass_t               es,
  input  logic                  es_is_load,
  input  bypass_t               ms,
  input  logic                  ms_data_ok,
  input  bypass_t               ws,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  hazard
);

  logic nonzero;
  logic es_hit;
  logic ms_hit;
  logic ws_hit;

  assign nonzero = (raddr != '0);
  assign es_hit  = es.valid && es.wen && (es.waddr == raddr) && nonzero;
  assign ms_hit  = ms.valid && ms.wen && (ms.waddr == raddr) && nonzero;
  assign ws_hit  = ws.valid && ws.wen && (ws.waddr == raddr) && nonzero;

  always_comb begin
    value = rf_rdata;
    if (!nonzero)    value = '0;
    else if (es_hit) value = es.wdata;
    else if (ms_hit) value = ms.wdata;
    else if (ws_hit) value = ws.wdata;
  end

  // A pending MEM load only matters when no younger EX write shadows it.
  assign hazard = uses && ((es_hit && es_is_load) || (!es_hit && ms_hit && !ms_data_ok));

endmodule

// File: rtl/decode_stage.sv
// ID stage: IF/ID register, instruction decode, operand forwarding and load-use stall.
// Handshake: a transfer to EX happens on a posedge where ds_to_es_valid && es_allowin.
module decode_stage #(
  parameter int DATA_WIDTH = decode_stage_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = decode_stage_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  fs_to_ds_valid,
  input  logic [DATA_WIDTH-1:0] fs_pc,
  input  logic [DATA_WIDTH-1:0] fs_inst,
  output logic                  ds_allowin,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  input  logic                  es_valid,
  input  logic                  es_wen,
  input  logic                  es_is_load,
  input  logic [ADDR_WIDTH-1:0] es_waddr,
  input  logic [DATA_WIDTH-1:0] es_wdata,
  input  logic                  ms_valid,
  input  logic                  ms_wen,
  input  logic                  ms_data_ok,
  input  logic [ADDR_WIDTH-1:0] ms_waddr,
  input  logic [DATA_WIDTH-1:0] ms_wdata,
  input  logic                  ws_valid,
  input  logic                  ws_wen,
  input  logic [ADDR_WIDTH-1:0] ws_waddr,
  input  logic [DATA_WIDTH-1:0] ws_wdata,
  input  logic                  es_allowin,
  output logic                  ds_to_es_valid,
  output logic [DATA_WIDTH-1:0] ds_pc,
  output logic [DATA_WIDTH-1:0] ds_inst,
  output logic [DATA_WIDTH-1:0] ds_src1,
  output logic [DATA_WIDTH-1:0] ds_src2,
  output logic [DATA_WIDTH-1:0] ds_imm,
  output logic [ADDR_WIDTH-1:0] ds_dest
);

  import decode_stage_pkg::*;

  logic       ds_valid;
  logic       ds_ready_go;
  logic       stall;
  logic       haz_rs;
  logic       haz_rt;
  logic       uses_rs;
  logic       uses_rt;
  logic [5:0] op;
  bypass_t    es_byp;
  bypass_t    ms_byp;
  bypass_t    ws_byp;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ds_valid <= 1'b0;
      ds_pc    <= '0;
      ds_inst  <= '0;
    end else if (flush) begin
      ds_valid <= 1'b0;
    end else if (ds_allowin) begin
      ds_valid <= fs_to_ds_valid;
      if (fs_to_ds_valid) begin
        ds_pc   <= fs_pc;
        ds_inst <= fs_inst;
      end
    end
  end

  assign op        = ds_inst[31:26];
  assign rf_raddr1 = ds_inst[25:21];
  assign rf_raddr2 = ds_inst[20:16];
  assign ds_imm    = {{(DATA_WIDTH-16){ds_inst[15]}}, ds_inst[15:0]};

  assign uses_rs = !((op == OP_J) || (op == OP_JAL));
  assign uses_rt = (op == OP_SPECIAL) || (op == OP_BEQ) || (op == OP_BNE) || is_store(op);

  always_comb begin
    ds_dest = ds_inst[20:16];
    if (op == OP_SPECIAL)                                    ds_dest = ds_inst[15:11];
    else if (op == OP_JAL)                                   ds_dest = REG_RA;
    else if (is_store(op) || op == OP_BEQ || op == OP_BNE)   ds_dest = '0;
  end

  assign es_byp = '{valid: es_valid, wen: es_wen, waddr: es_waddr, wdata: es_wdata};
  assign ms_byp = '{valid: ms_valid, wen: ms_wen, waddr: ms_waddr, wdata: ms_wdata};
  assign ws_byp = '{valid: ws_valid, wen: ws_wen, waddr: ws_waddr, wdata: ws_wdata};

  fwd_mux u_fwd_rs (
    .raddr      (rf_raddr1),
    .uses       (uses_rs),
    .es         (es_byp),
    .es_is_load (es_is_load),
    .ms         (ms_byp),
    .ms_data_ok (ms_data_ok),
    .ws         (ws_byp),
    .rf_rdata   (rf_rdata1),
    .value      (ds_src1),
    .hazard     (haz_rs)
  );

  fwd_mux u_fwd_rt (
    .raddr      (rf_raddr2),
    .uses       (uses_rt),
    .es         (es_byp),
    .es_is_load (es_is_load),
    .ms         (ms_byp),
    .ms_data_ok (ms_data_ok),
    .ws         (ws_byp),
    .rf_rdata   (rf_rdata2),
    .value      (ds_src2),
    .hazard     (haz_rt)
  );

  assign stall          = haz_rs || haz_rt;
  assign ds_ready_go    = !stall;
  assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid && ds_ready_go && !flush;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed hazard scenarios, then random traffic checked
// against a reference model through an expected-transfer queue.
module tb_decode_stage;

  localparam int W = 165;

  logic        clk = 1'b0;
  logic        resetn, flush, fs_to_ds_valid, ds_allowin;
  logic [31:0] fs_pc, fs_inst;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        es_valid, es_wen, es_is_load, ms_valid, ms_wen, ms_data_ok, ws_valid, ws_wen;
  logic [4:0]  es_waddr, ms_waddr, ws_waddr;
  logic [31:0] es_wdata, ms_wdata, ws_wdata;
  logic        es_allowin, ds_to_es_valid;
  logic [31:0] ds_pc, ds_inst, ds_src1, ds_src2, ds_imm;
  logic [4:0]  ds_dest;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic         mon_en = 1'b0;
  logic         exp_allowin, exp_tvalid;
  logic         m_valid;
  logic [31:0]  m_pc, m_inst;
  logic [31:0]  rf [32];

  decode_stage dut (
    .clk(clk), .resetn(resetn), .flush(flush), .fs_to_ds_valid(fs_to_ds_valid),
    .fs_pc(fs_pc), .fs_inst(fs_inst), .ds_allowin(ds_allowin),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .es_valid(es_valid), .es_wen(es_wen), .es_is_load(es_is_load), .es_waddr(es_waddr), .es_wdata(es_wdata),
    .ms_valid(ms_valid), .ms_wen(ms_wen), .ms_data_ok(ms_data_ok), .ms_waddr(ms_waddr), .ms_wdata(ms_wdata),
    .ws_valid(ws_valid), .ws_wen(ws_wen), .ws_waddr(ws_waddr), .ws_wdata(ws_wdata),
    .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid), .ds_pc(ds_pc), .ds_inst(ds_inst),
    .ds_src1(ds_src1), .ds_src2(ds_src2), .ds_imm(ds_imm), .ds_dest(ds_dest)
  );

  // ---------------- clock / register file model ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] rf_init(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) rf[i] <= rf_init(i);
    end else if (ws_valid && ws_wen && ws_waddr != 5'd0) begin
      rf[ws_waddr] <= ws_wdata;
    end
  end

  assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : rf[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : rf[rf_raddr2];

  // ---------------- reference model ----------------
  function automatic int producer(input logic [4:0] r);
    logic       live [3];
    logic [4:0] dst  [3];
    live = '{es_valid && es_wen, ms_valid && ms_wen, ws_valid && ws_wen};
    dst  = '{es_waddr, ms_waddr, ws_waddr};
    if (r == 5'd0) return 3;
    for (int i = 0; i < 3; i++) if (live[i] && dst[i] == r) return i;
    return 3;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r);
    case (producer(r))
      0:       return es_wdata;
      1:       return ms_wdata;
      2:       return ws_wdata;
      default: return (r == 5'd0) ? 32'd0 : rf[r];
    endcase
  endfunction

  function automatic logic not_ready(input logic [4:0] r, input logic used);
    int p;
    p = producer(r);
    if (!used) return 1'b0;
    if (p == 0) return es_is_load;
    if (p == 1) return !ms_data_ok;
    return 1'b0;
  endfunction

  function automatic logic reads_rs(input logic [5:0] op);
    return !(op == 6'h02 || op == 6'h03);
  endfunction

  function automatic logic reads_rt(input logic [5:0] op);
    return op == 6'h00 || op == 6'h04 || op == 6'h05 || (op >= 6'h28 && op <= 6'h2f);
  endfunction

  function automatic logic [4:0] dest_of(input logic [31:0] inst);
    logic [5:0] op;
    op = inst[31:26];
    if (op == 6'h00) return inst[15:11];
    if (op == 6'h03) return 5'd31;
    if ((op >= 6'h28 && op <= 6'h2f) || op == 6'h04 || op == 6'h05) return 5'd0;
    return inst[20:16];
  endfunction

  function automatic logic [31:0] addu(input int d, input int s, input int t);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'h00, 6'h21};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops [9];
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2b, 6'h09, 6'h28};
    return {ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_byp();
    es_valid = 0; es_wen = 0; es_is_load = 0; es_waddr = 0; es_wdata = 0;
    ms_valid = 0; ms_wen = 0; ms_data_ok = 1; ms_waddr = 0; ms_wdata = 0;
    ws_valid = 0; ws_wen = 0; ws_waddr = 0; ws_wdata = 0;
  endtask

  task automatic load(input logic [31:0] pc, input logic [31:0] inst);
    idle_byp();
    fs_to_ds_valid = 1; fs_pc = pc; fs_inst = inst; es_allowin = 1;
    tick();
    fs_to_ds_valid = 0; es_allowin = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rand_cycle();
    logic        st;
    logic [5:0]  op;
    logic        n_valid;
    logic [31:0] n_pc, n_inst;
    flush          = ($urandom_range(0, 9) == 0);
    fs_to_ds_valid = ($urandom_range(0, 9) < 6);
    fs_pc          = $urandom & 32'hffff_fffc;
    fs_inst        = rand_inst();
    es_allowin     = ($urandom_range(0, 9) < 7);
    es_valid = 1'($urandom); es_wen = 1'($urandom); es_is_load = ($urandom_range(0, 3) == 0);
    es_waddr = 5'($urandom_range(0, 3)); es_wdata = $urandom;
    ms_valid = 1'($urandom); ms_wen = 1'($urandom); ms_data_ok = ($urandom_range(0, 3) != 0);
    ms_waddr = 5'($urandom_range(0, 3)); ms_wdata = $urandom;
    ws_valid = 1'($urandom); ws_wen = 1'($urandom);
    ws_waddr = 5'($urandom_range(0, 3)); ws_wdata = $urandom;
    op = m_inst[31:26];
    st = m_valid && (not_ready(m_inst[25:21], reads_rs(op)) || not_ready(m_inst[20:16], reads_rt(op)));
    exp_allowin = !m_valid || (!st && es_allowin);
    exp_tvalid  = m_valid && !st && !flush;
    if (exp_tvalid && es_allowin)
      exp_q.push_back({m_pc, m_inst, operand(m_inst[25:21]), operand(m_inst[20:16]),
                       {{16{m_inst[15]}}, m_inst[15:0]}, dest_of(m_inst)});
    n_valid = m_valid; n_pc = m_pc; n_inst = m_inst;
    if (flush) n_valid = 1'b0;
    else if (exp_allowin) begin
      n_valid = fs_to_ds_valid;
      if (fs_to_ds_valid) begin n_pc = fs_pc; n_inst = fs_inst; end
    end
    tick();
    m_valid = n_valid; m_pc = n_pc; m_inst = n_inst;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (ds_allowin !== exp_allowin || ds_to_es_valid !== exp_tvalid) begin
        errors++;
        $display("FAIL handshake: got allowin=%b valid=%b expected allowin=%b valid=%b",
                 ds_allowin, ds_to_es_valid, exp_allowin, exp_tvalid);
      end
      if (ds_to_es_valid && es_allowin) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL transfer: got pc=%h with no transfer expected", ds_pc);
        end else begin
          logic [W-1:0] exp, act;
          exp = exp_q.pop_front();
          act = {ds_pc, ds_inst, ds_src1, ds_src2, ds_imm, ds_dest};
          if (act !== exp) begin
            errors++;
            $display("FAIL transfer: got %h expected %h", act, exp);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn = 0; flush = 0; fs_to_ds_valid = 0; fs_pc = 0; fs_inst = 0; es_allowin = 0;
    exp_allowin = 1; exp_tvalid = 0; m_valid = 0; m_pc = 0; m_inst = 0;
    idle_byp();
    tick(); tick();
    check("reset_valid", 32'(ds_to_es_valid), 0);
    check("reset_pc", ds_pc, 0);
    check("reset_allowin", 32'(ds_allowin), 1);
    check("reset_dest", 32'(ds_dest), 0);
    check("reset_imm", ds_imm, 0);
    resetn = 1;

    // EX result beats MEM result for rs; rt comes from the register file
    load(32'h100, addu(3, 1, 2));
    es_valid = 1; es_wen = 1; es_waddr = 1; es_wdata = 32'h11;
    ms_valid = 1; ms_wen = 1; ms_waddr = 1; ms_wdata = 32'h22;
    #1;
    check("ex_fwd_src1", ds_src1, 32'h11);
    check("ex_fwd_src2", ds_src2, rf_init(2));
    check("ex_fwd_dest", 32'(ds_dest), 3);
    check("ex_fwd_valid", 32'(ds_to_es_valid), 1);

    // WB write in the same cycle as the read
    load(32'h104, addu(7, 4, 0));
    ws_valid = 1; ws_wen = 1; ws_waddr = 4; ws_wdata = 32'hdeadbeef;
    #1;
    check("wb_same_cycle", ds_src1, 32'hdeadbeef);
    tick();
    ws_valid = 0; ws_wen = 0;
    #1;
    check("wb_after_write", ds_src1, 32'hdeadbeef);

    // Load-use stall, then MEM forward
    load(32'h108, addu(6, 5, 0));
    es_valid = 1; es_wen = 1; es_waddr = 5; es_is_load = 1; es_allowin = 1;
    #1;
    check("lu_valid", 32'(ds_to_es_valid), 0);
    check("lu_allowin", 32'(ds_allowin), 0);
    fs_to_ds_valid = 1; fs_pc = 32'h200; fs_inst = addu(1, 1, 1);
    tick();
    fs_to_ds_valid = 0;
    es_valid = 0; es_is_load = 0;
    ms_valid = 1; ms_wen = 1; ms_waddr = 5; ms_wdata = 32'h55; ms_data_ok = 0;
    #1;
    check("lu_pc_held", ds_pc, 32'h108);
    check("mem_not_ok_stall", 32'(ds_to_es_valid), 0);
    ms_data_ok = 1;
    #1;
    check("lu_release", 32'(ds_to_es_valid), 1);
    check("lu_mem_fwd", ds_src1, 32'h55);

    // $0 is never forwarded and never stalls
    load(32'h10c, addu(6, 0, 2));
    es_valid = 1; es_wen = 1; es_waddr = 0; es_wdata = 32'h7; es_is_load = 1;
    #1;
    check("zero_src1", ds_src1, 0);
    check("zero_no_stall", 32'(ds_to_es_valid), 1);

    // Backpressure holds the stage, then flush beats an incoming instruction
    load(32'h110, 32'h8c22_0004);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_inst", ds_inst, 32'h8c22_0004);
    end
    flush = 1; fs_to_ds_valid = 1; fs_pc = 32'h300; fs_inst = 32'hffff_ffff;
    #1;
    check("flush_comb_valid", 32'(ds_to_es_valid), 0);
    tick();
    flush = 0; fs_to_ds_valid = 0;
    #1;
    check("flush_valid", 32'(ds_to_es_valid), 0);
    check("flush_inst_kept", ds_inst, 32'h8c22_0004);
    check("flush_allowin", 32'(ds_allowin), 1);

    // Reset while holding a valid instruction
    load(32'h114, addu(1, 2, 3));
    check("pre_reset_valid", 32'(ds_to_es_valid), 1);
    resetn = 0;
    tick();
    check("midreset_valid", 32'(ds_to_es_valid), 0);
    check("midreset_pc", ds_pc, 0);
    check("midreset_allowin", 32'(ds_allowin), 1);
    resetn = 1;
    m_valid = 0; m_pc = 0; m_inst = 0;

    // Random traffic against the reference model
    mon_en = 1;
    for (int n = 0; n < 600; n++) rand_cycle();
    mon_en = 0;
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
